hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 8-bit pipelined processor. Drives the enable and flush controls of the IF/ID and ID/EX pipeline registers and the PC source select. It resolves load-use hazards, taken-branch flushes, HLT, and a multi-cycle interrupt-entry sequence. It sits beside the decode stage and produces the run/flush signals consumed by the PC register, the IF/ID register and the ID/EX register.

## Interface
- DRAIN_CYCLES, 2: number of bubble cycles inserted before interrupt PC push (1..7)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  2  destination register of the instruction in EX
- id_rs, id_rt  in  2 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- id_is_hlt  in  1  ID holds HLT
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- ex_is_rti  in  1  RTI executing in EX
- irq  in  1  interrupt request, level, already synchronized to clk
- run_F  out  1  PC enable (1 = advance, 0 = hold)
- run_D  out  1  IF/ID enable (1 = load, 0 = freeze)
- flush_D  out  1  clear IF/ID to NOP
- flush_E  out  1  clear ID/EX to NOP (bubble)
- pc_sel  out  2  00 = PC+1, 01 = branch target, 10 = interrupt vector
- int_push  out  1  datapath pushes the saved PC (pc_reg of ID) to stack
- irq_ack  out  1  one-cycle interrupt acknowledge
- halted  out  1  core is in HALT

## Operation
- Registered state:
  - FSM {RUN, HALT, DRAIN, PUSH, VEC}
  - 3-bit drain counter
  - in_isr flag
- Outputs are combinational from state and inputs. Defaults: run_F = 1, run_D = 1, flush_D = 0, flush_E = 0, pc_sel = 00, int_push = 0, irq_ack = 0, halted = 0.
- load_use = ex_mem_read & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd)).
- irq_ok = irq & ~in_isr.
- RUN, evaluated in priority order:
  1. branch_taken_ex: flush_D = 1, flush_E = 1, pc_sel = 01; stay RUN. Load-use, irq and HLT are ignored this cycle.
  2. load_use: run_F = 0, run_D = 0, flush_E = 1; stay RUN.
  3. irq_ok: run_F = 0, run_D = 0, flush_E = 1; counter <= DRAIN_CYCLES-1; go to DRAIN.
  4. id_is_hlt: run_F = 0, run_D = 0, flush_E = 1; go to HALT.
- HALT:
  - run_F = 0, run_D = 0, flush_E = 1, halted = 1.
  - irq_ok: counter <= DRAIN_CYCLES-1, go to DRAIN. Otherwise stay HALT.
  - irq while in_isr does not wake the core.
- DRAIN:
  - run_F = 0, run_D = 0, flush_E = 1.
  - branch_taken_ex: abort. Apply the branch outputs (flush_D, flush_E, pc_sel = 01, run_F = 1, run_D = 1) and go to RUN. irq stays pending and re-enters next cycle.
  - Else counter == 0: go to PUSH. Else decrement the counter.
- PUSH: run_F = 0, run_D = 0, flush_E = 1, int_push = 1; go to VEC.
- VEC: pc_sel = 10, run_F = 1, flush_D = 1, flush_E = 1, irq_ack = 1; set in_isr; go to RUN.
- in_isr is cleared on any cycle with ex_is_rti = 1 and state RUN. When set and cleared in the same cycle, set wins.
- HLT's saved PC is its own pc_reg, so HLT re-executes after the ISR returns and halts again. This is intended.

## Timing
- Reset (asynchronous, active-high):
  - Immediately: state = RUN, counter = 0, in_isr = 0.
  - While reset is high, outputs are forced to the defaults: run_F = 1, run_D = 1, all others 0.
  - Reset mid-sequence (DRAIN/PUSH/HALT) abandons the sequence with no irq_ack.
- Load-use stall: exactly 1 cycle. On the next cycle the load has left EX, so load_use deasserts.
- Branch flush: same cycle as branch_taken_ex. Branch target is loaded on the next clk edge.
- Interrupt latency from irq_ok sampled in RUN to the VEC cycle: 1 + DRAIN_CYCLES + 1 cycles. With default DRAIN_CYCLES = 2:
  - cycle 0: RUN detects irq_ok
  - cycles 1–2: DRAIN
  - cycle 3: PUSH
  - cycle 4: VEC, irq_ack
- irq_ack and int_push are each exactly one cycle wide per interrupt.
- irq deasserting during DRAIN/PUSH does not cancel the sequence. Only reset or a taken branch in DRAIN cancels it.

## Test plan
- Load r2, next instruction reads rs = r2 → one cycle of run_F = 0, run_D = 0, flush_E = 1, then normal; no stall when id_uses_rs = 0.
- branch_taken_ex with load_use also high → flush_D = 1, flush_E = 1, pc_sel = 01, run_F = 1, same cycle; no stall.
- irq pulse in RUN, DRAIN_CYCLES = 2 → DRAIN ×2, int_push at +3, irq_ack with pc_sel = 10 at +4, in_isr = 1; a second irq is ignored until ex_is_rti.
- HLT decoded → halted = 1 held for 20 cycles; irq → halted drops, irq_ack 4 cycles later.
- branch_taken_ex in first DRAIN cycle with irq held → branch outputs, RUN, re-enter DRAIN next cycle, irq_ack delivered.
- reset asserted during PUSH → outputs return to defaults asynchronously; no irq_ack; in_isr = 0 after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 8-bit pipelined core.
//
// Decides, every cycle, whether the PC and the IF/ID register advance. It also
// decides whether IF/ID and ID/EX are cleared to NOPs, and where the next PC
// comes from. Four situations are handled:
//   - load-use hazards (one-cycle bubble)
//   - taken branches (flush the two younger instructions)
//   - HLT (freeze until an interrupt arrives)
//   - interrupt entry (drain, push the saved PC, jump to the vector)
//
// Parameters:
//   DRAIN_CYCLES     bubble cycles inserted before the PC push (1..7)
// Inputs:
//   clk_i            system clock, rising edge
//   reset_i          asynchronous, active-high; clears all state
//   ex_mem_read_i    instruction in EX is a load
//   ex_rd_i          destination register of the EX instruction
//   id_rs_i/id_rt_i  source registers of the ID instruction
//   id_uses_rs_i/id_uses_rt_i  ID instruction really reads rs / rt
//   id_is_hlt_i      ID holds HLT
//   branch_taken_ex_i  branch/jump resolved taken in EX
//   ex_is_rti_i      RTI executing in EX
//   irq_i            level interrupt request, already synchronous to clk_i
// Outputs:
//   run_F_o          PC enable
//   run_D_o          IF/ID enable
//   flush_D_o        clear IF/ID
//   flush_E_o        clear ID/EX
//   pc_sel_o         00 PC+1, 01 branch target, 10 interrupt vector
//   int_push_o       push the saved PC to the stack
//   irq_ack_o        one-cycle interrupt acknowledge
//   halted_o         core is halted
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ex_mem_read_i,
  input  logic [1:0] ex_rd_i,
  input  logic [1:0] id_rs_i,
  input  logic [1:0] id_rt_i,
  input  logic       id_uses_rs_i,
  input  logic       id_uses_rt_i,
  input  logic       id_is_hlt_i,
  input  logic       branch_taken_ex_i,
  input  logic       ex_is_rti_i,
  input  logic       irq_i,
  output logic       run_F_o,
  output logic       run_D_o,
  output logic       flush_D_o,
  output logic       flush_E_o,
  output logic [1:0] pc_sel_o,
  output logic       int_push_o,
  output logic       irq_ack_o,
  output logic       halted_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT,
    S_DRAIN,
    S_PUSH,
    S_VEC
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] drainCnt_q, drainCnt_d;
  logic       inIsr_q, inIsr_d;

  logic       loadUse;
  logic       irqOk;

  // A load in EX whose destination is really read by the ID instruction
  // cannot forward in time, so ID has to wait one cycle.
  assign loadUse = ex_mem_read_i &
                   ((id_uses_rs_i & (id_rs_i == ex_rd_i)) |
                    (id_uses_rt_i & (id_rt_i == ex_rd_i)));

  // Interrupts are not nested: a request is only accepted outside an ISR.
  assign irqOk = irq_i & ~inIsr_q;

  // State register: the sequencer state, the drain counter and the ISR flag.
  // All of them return to their idle values as soon as reset rises.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_RUN;
      drainCnt_q <= 3'd0;
      inIsr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      inIsr_q    <= inIsr_d;
    end
  end

  // Next-state and output decode. Every output starts at its "free running"
  // value, and each state overrides only what it needs. Reset forces the
  // defaults back at the end, because the outputs also depend on the inputs.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    inIsr_d    = inIsr_q;
    run_F_o    = 1'b1;
    run_D_o    = 1'b1;
    flush_D_o  = 1'b0;
    flush_E_o  = 1'b0;
    pc_sel_o   = 2'b00;
    int_push_o = 1'b0;
    irq_ack_o  = 1'b0;
    halted_o   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (ex_is_rti_i) begin
          inIsr_d = 1'b0;
        end
        // A taken branch kills the ID instruction, so any hazard,
        // interrupt or HLT it carried no longer matters.
        if (branch_taken_ex_i) begin
          flush_D_o = 1'b1;
          flush_E_o = 1'b1;
          pc_sel_o  = 2'b01;
        end else if (loadUse) begin
          run_F_o   = 1'b0;
          run_D_o   = 1'b0;
          flush_E_o = 1'b1;
        end else if (irqOk) begin
          run_F_o    = 1'b0;
          run_D_o    = 1'b0;
          flush_E_o  = 1'b1;
          drainCnt_d = DRAIN_INIT;
          state_d    = S_DRAIN;
        end else if (id_is_hlt_i) begin
          run_F_o   = 1'b0;
          run_D_o   = 1'b0;
          flush_E_o = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_HALT: begin
        run_F_o   = 1'b0;
        run_D_o   = 1'b0;
        flush_E_o = 1'b1;
        halted_o  = 1'b1;
        if (irqOk) begin
          drainCnt_d = DRAIN_INIT;
          state_d    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // A branch still in flight would leave ID holding the wrong PC to
        // save. Take the branch first; the held irq re-enters from RUN.
        if (branch_taken_ex_i) begin
          flush_D_o = 1'b1;
          flush_E_o = 1'b1;
          pc_sel_o  = 2'b01;
          state_d   = S_RUN;
        end else begin
          run_F_o   = 1'b0;
          run_D_o   = 1'b0;
          flush_E_o = 1'b1;
          if (drainCnt_q == 3'd0) begin
            state_d = S_PUSH;
          end else begin
            drainCnt_d = drainCnt_q - 3'd1;
          end
        end
      end

      S_PUSH: begin
        run_F_o    = 1'b0;
        run_D_o    = 1'b0;
        flush_E_o  = 1'b1;
        int_push_o = 1'b1;
        state_d    = S_VEC;
      end

      S_VEC: begin
        pc_sel_o  = 2'b10;
        flush_D_o = 1'b1;
        flush_E_o = 1'b1;
        irq_ack_o = 1'b1;
        inIsr_d   = 1'b1;
        state_d   = S_RUN;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase

    if (reset_i) begin
      run_F_o    = 1'b1;
      run_D_o    = 1'b1;
      flush_D_o  = 1'b0;
      flush_E_o  = 1'b0;
      pc_sel_o   = 2'b00;
      int_push_o = 1'b0;
      irq_ack_o  = 1'b0;
      halted_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl with DRAIN_CYCLES = 2.
// The bench runs in three parts:
//   - A table of single-cycle vectors, each applied from a fresh reset.
//   - Hand-written multi-cycle sequences for the stall, interrupt, halt,
//     drain-abort and reset corner cases.
//   - Randomized stimulus checked against a cycle-count reference model.
module tb_hazard_ctrl;

  localparam int DRAIN = 2;

  // Output vector order: run_F run_D flush_D flush_E pc_sel[1:0] int_push irq_ack halted
  localparam logic [8:0] O_DEF    = 9'b1_1_0_0_00_0_0_0;
  localparam logic [8:0] O_STALL  = 9'b0_0_0_1_00_0_0_0;
  localparam logic [8:0] O_BRANCH = 9'b1_1_1_1_01_0_0_0;
  localparam logic [8:0] O_HALT   = 9'b0_0_0_1_00_0_0_1;
  localparam logic [8:0] O_PUSH   = 9'b0_0_0_1_00_1_0_0;
  localparam logic [8:0] O_VEC    = 9'b1_1_1_1_10_0_1_0;

  typedef struct packed {
    logic       exMemRead;
    logic [1:0] exRd;
    logic [1:0] idRs;
    logic [1:0] idRt;
    logic       usesRs;
    logic       usesRt;
    logic       isHlt;
    logic       branch;
    logic       rti;
    logic       irq;
  } in_t;

  typedef struct {
    in_t        stim;
    logic [8:0] expOut;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       ex_mem_read_i = 1'b0;
  logic [1:0] ex_rd_i = 2'd0;
  logic [1:0] id_rs_i = 2'd0;
  logic [1:0] id_rt_i = 2'd0;
  logic       id_uses_rs_i = 1'b0;
  logic       id_uses_rt_i = 1'b0;
  logic       id_is_hlt_i = 1'b0;
  logic       branch_taken_ex_i = 1'b0;
  logic       ex_is_rti_i = 1'b0;
  logic       irq_i = 1'b0;
  logic       run_F_o, run_D_o, flush_D_o, flush_E_o;
  logic [1:0] pc_sel_o;
  logic       int_push_o, irq_ack_o, halted_o;

  int errors = 0;
  int checks = 0;

  // Reference model state: position inside an interrupt entry (0 = none,
  // 1..DRAIN drain bubbles, DRAIN+1 push, DRAIN+2 vector), halt and ISR flags.
  int seqPos = 0;
  bit haltM  = 1'b0;
  bit inIsrM = 1'b0;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .ex_mem_read_i(ex_mem_read_i),
    .ex_rd_i(ex_rd_i),
    .id_rs_i(id_rs_i),
    .id_rt_i(id_rt_i),
    .id_uses_rs_i(id_uses_rs_i),
    .id_uses_rt_i(id_uses_rt_i),
    .id_is_hlt_i(id_is_hlt_i),
    .branch_taken_ex_i(branch_taken_ex_i),
    .ex_is_rti_i(ex_is_rti_i),
    .irq_i(irq_i),
    .run_F_o(run_F_o),
    .run_D_o(run_D_o),
    .flush_D_o(flush_D_o),
    .flush_E_o(flush_E_o),
    .pc_sel_o(pc_sel_o),
    .int_push_o(int_push_o),
    .irq_ack_o(irq_ack_o),
    .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case some sequence never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: act=timeout req=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mk(input logic exMemRead, input logic [1:0] exRd,
                             input logic [1:0] idRs, input logic [1:0] idRt,
                             input logic usesRs, input logic usesRt,
                             input logic isHlt, input logic branch,
                             input logic rti, input logic irq);
    in_t s;
    s.exMemRead = exMemRead;
    s.exRd      = exRd;
    s.idRs      = idRs;
    s.idRt      = idRt;
    s.usesRs    = usesRs;
    s.usesRt    = usesRt;
    s.isHlt     = isHlt;
    s.branch    = branch;
    s.rti       = rti;
    s.irq       = irq;
    return s;
  endfunction

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input in_t s);
    ex_mem_read_i     = s.exMemRead;
    ex_rd_i           = s.exRd;
    id_rs_i           = s.idRs;
    id_rt_i           = s.idRt;
    id_uses_rs_i      = s.usesRs;
    id_uses_rt_i      = s.usesRt;
    id_is_hlt_i       = s.isHlt;
    branch_taken_ex_i = s.branch;
    ex_is_rti_i       = s.rti;
    irq_i             = s.irq;
  endtask

  // Compare the full output vector with the required one.
  task automatic checkOutput(input string name, input logic [8:0] expOut);
    logic [8:0] act;
    act = {run_F_o, run_D_o, flush_D_o, flush_E_o, pc_sel_o,
           int_push_o, irq_ack_o, halted_o};
    checks++;
    if (act !== expOut) begin
      errors++;
      $display("[TB] FAIL %s: act=%b req=%b (runF runD flD flE pcsel push ack halt)",
               name, act, expOut);
    end
  endtask

  // Move to the next cycle slot, 2 ns after the rising edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #2;
  endtask

  // Apply inputs, sample mid-cycle, then advance.
  task automatic stepCheck(input in_t s, input logic [8:0] expOut, input string name);
    applyStimulus(s);
    #3;
    checkOutput(name, expOut);
    nextCycle();
  endtask

  task automatic doReset();
    applyStimulus('0);
    reset_i = 1'b1;
    nextCycle();
    reset_i = 1'b0;
  endtask

  function automatic bit modelLoadUse(input in_t s);
    return s.exMemRead && ((s.usesRs && s.idRs == s.exRd) ||
                           (s.usesRt && s.idRt == s.exRd));
  endfunction

  // Expected outputs for this cycle, given the model state and the inputs.
  function automatic logic [8:0] modelOut(input in_t s);
    if (seqPos >= 1 && seqPos <= DRAIN) return s.branch ? O_BRANCH : O_STALL;
    if (seqPos == DRAIN + 1) return O_PUSH;
    if (seqPos == DRAIN + 2) return O_VEC;
    if (haltM) return O_HALT;
    if (s.branch) return O_BRANCH;
    if (modelLoadUse(s) || (s.irq && !inIsrM) || s.isHlt) return O_STALL;
    return O_DEF;
  endfunction

  // Model state change at the clock edge that ends this cycle.
  task automatic modelAdvance(input in_t s);
    bit irqOkM;
    irqOkM = s.irq && !inIsrM;
    if (seqPos >= 1 && seqPos <= DRAIN + 1) begin
      if (seqPos <= DRAIN && s.branch) seqPos = 0;
      else seqPos++;
    end else if (seqPos == DRAIN + 2) begin
      seqPos = 0;
      inIsrM = 1'b1;
    end else if (haltM) begin
      if (irqOkM) begin
        haltM  = 1'b0;
        seqPos = 1;
      end
    end else begin
      if (s.rti) inIsrM = 1'b0;
      if (!s.branch && !modelLoadUse(s)) begin
        if (irqOkM) seqPos = 1;
        else if (s.isHlt) haltM = 1'b1;
      end
    end
  endtask

  task automatic modelReset();
    seqPos = 0;
    haltM  = 1'b0;
    inIsrM = 1'b0;
  endtask

  initial begin
    vec_t table_q[10];
    in_t  zero;
    in_t  irqOnly;
    in_t  s;
    zero    = '0;
    irqOnly = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Single-cycle vectors, each from a fresh reset (RUN, not in ISR).
    table_q[0] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_DEF};
    table_q[1] = '{mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 0), O_STALL};
    table_q[2] = '{mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 0), O_DEF};
    table_q[3] = '{mk(1, 3, 0, 3, 0, 1, 0, 0, 0, 0), O_STALL};
    table_q[4] = '{mk(0, 2, 2, 2, 1, 1, 0, 0, 0, 0), O_DEF};
    table_q[5] = '{mk(1, 2, 2, 0, 1, 0, 0, 1, 0, 0), O_BRANCH};
    table_q[6] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), O_BRANCH};
    table_q[7] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_STALL};
    table_q[8] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_STALL};
    table_q[9] = '{mk(1, 2, 1, 3, 1, 1, 0, 0, 0, 0), O_DEF};

    nextCycle();
    reset_i = 1'b1;
    #3;
    checkOutput("resetDefaults", O_DEF);
    nextCycle();
    reset_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      doReset();
      stepCheck(table_q[i].stim, table_q[i].expOut, $sformatf("vec%0d", i));
    end

    // Load-use stalls exactly one cycle.
    doReset();
    stepCheck(mk(1, 2, 2, 0, 1, 0, 0, 0, 0, 0), O_STALL, "loadUseStall");
    stepCheck(zero, O_DEF, "loadUseReleased");

    // Full interrupt entry, masking while in the ISR, and unmasking by RTI.
    doReset();
    stepCheck(irqOnly, O_STALL, "irqDetect");
    stepCheck(zero, O_STALL, "irqDrain1");
    stepCheck(zero, O_STALL, "irqDrain2");
    stepCheck(zero, O_PUSH, "irqPush");
    stepCheck(zero, O_VEC, "irqVec");
    stepCheck(irqOnly, O_DEF, "irqMasked1");
    stepCheck(irqOnly, O_DEF, "irqMasked2");
    stepCheck(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_DEF, "irqWithRti");
    stepCheck(irqOnly, O_STALL, "irqAfterRti");
    stepCheck(zero, O_STALL, "irq2Drain1");
    stepCheck(zero, O_STALL, "irq2Drain2");
    stepCheck(zero, O_PUSH, "irq2Push");
    stepCheck(zero, O_VEC, "irq2Vec");

    // HLT holds for 20 cycles, then an interrupt wakes the core.
    doReset();
    stepCheck(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_STALL, "hltDecode");
    for (int i = 0; i < 20; i++) stepCheck(zero, O_HALT, $sformatf("halted%0d", i));
    stepCheck(irqOnly, O_HALT, "haltIrq");
    stepCheck(zero, O_STALL, "haltDrain1");
    stepCheck(zero, O_STALL, "haltDrain2");
    stepCheck(zero, O_PUSH, "haltPush");
    stepCheck(zero, O_VEC, "haltAck");
    // Halting again inside the ISR: irq must not wake it.
    stepCheck(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), O_STALL, "hltInIsr");
    for (int i = 0; i < 3; i++) stepCheck(irqOnly, O_HALT, $sformatf("haltIsrIrq%0d", i));

    // Taken branch in the first drain cycle aborts, irq re-enters.
    doReset();
    stepCheck(irqOnly, O_STALL, "abortDetect");
    stepCheck(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), O_BRANCH, "abortBranch");
    stepCheck(irqOnly, O_STALL, "abortReenter");
    stepCheck(zero, O_STALL, "abortDrain1");
    stepCheck(zero, O_STALL, "abortDrain2");
    stepCheck(zero, O_PUSH, "abortPush");
    stepCheck(zero, O_VEC, "abortAck");

    // Reset during PUSH abandons the entry with no acknowledge.
    doReset();
    stepCheck(irqOnly, O_STALL, "rstDetect");
    stepCheck(zero, O_STALL, "rstDrain1");
    stepCheck(zero, O_STALL, "rstDrain2");
    applyStimulus(zero);
    #3;
    checkOutput("rstPushBefore", O_PUSH);
    reset_i = 1'b1;
    #1;
    checkOutput("rstAsyncDefaults", O_DEF);
    applyStimulus(mk(1, 2, 2, 0, 1, 0, 0, 1, 0, 1));
    #1;
    checkOutput("rstForcesDefaults", O_DEF);
    nextCycle();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) stepCheck(zero, O_DEF, $sformatf("rstNoAck%0d", i));
    // Reset inside an ISR clears the ISR flag.
    stepCheck(irqOnly, O_STALL, "isrDetect");
    stepCheck(zero, O_STALL, "isrDrain1");
    stepCheck(zero, O_STALL, "isrDrain2");
    stepCheck(zero, O_PUSH, "isrPush");
    stepCheck(zero, O_VEC, "isrVec");
    stepCheck(irqOnly, O_DEF, "isrMasked");
    doReset();
    stepCheck(irqOnly, O_STALL, "isrClearedByReset");

    // Randomized run against the reference model, with occasional resets.
    doReset();
    modelReset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        applyStimulus(zero);
        reset_i = 1'b1;
        #3;
        checkOutput($sformatf("rndReset%0d", i), O_DEF);
        modelReset();
        nextCycle();
        reset_i = 1'b0;
      end else begin
        s.exMemRead = ($urandom_range(2) == 0);
        s.exRd      = 2'($urandom_range(3));
        s.idRs      = 2'($urandom_range(3));
        s.idRt      = 2'($urandom_range(3));
        s.usesRs    = 1'($urandom_range(1));
        s.usesRt    = 1'($urandom_range(1));
        s.isHlt     = ($urandom_range(19) == 0);
        s.branch    = ($urandom_range(7) == 0);
        s.rti       = ($urandom_range(9) == 0);
        s.irq       = ($urandom_range(5) == 0);
        applyStimulus(s);
        #3;
        checkOutput($sformatf("rnd%0d", i), modelOut(s));
        modelAdvance(s);
        nextCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
